// File: rtl/floo_hbm_resp_delay.sv
// Fixed-latency in-order delay buffer for HBM responses: every accepted beat is
// held for at least Latency cycles, then released in FIFO order with valid/ready.
module floo_hbm_resp_delay #(
    parameter int unsigned Latency   = 100,
    parameter int unsigned Depth     = 32,
    parameter int unsigned DataWidth = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DataWidth-1:0]       in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DataWidth-1:0]       out_data_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned RemW = (Latency > 1) ? $clog2(Latency) : 1;
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    localparam logic [RemW-1:0] RemInit  = RemW'(Latency - 1);
    localparam logic [PtrW-1:0] PtrLast  = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] CntFull  = CntW'(Depth);

    generate
        if (Latency < 1 || Depth < 1) begin : g_bad_params
            $error("floo_hbm_resp_delay: Latency and Depth must both be >= 1");
        end
    endgenerate

    logic [DataWidth-1:0] data_q [Depth];
    logic [RemW-1:0]      rem_q  [Depth];
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic [CntW-1:0]      count_q;

    logic push;
    logic pop;

    // in_ready looks only at the registered count; a pop while full frees
    // the slot for the following cycle, never the same one.
    always_comb begin
        in_ready_o  = !rst_i && (count_q < CntFull);
        out_valid_o = (count_q != '0) && (rem_q[rd_ptr_q] == '0);
        out_data_o  = data_q[rd_ptr_q];
        count_o     = count_q;
        push        = in_valid_i && in_ready_o;
        pop         = out_valid_o && out_ready_i;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            data_q[wr_ptr_q] <= in_data_i;
        end
    end

    // Every entry ages every cycle, so beats queued behind a stalled head
    // keep maturing; stale slots just sit at zero until overwritten.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < Depth; i++) begin
            if (rst_i) begin
                rem_q[i] <= '0;
            end else if (push && (wr_ptr_q == PtrW'(i))) begin
                rem_q[i] <= RemInit;
            end else if (rem_q[i] != '0) begin
                rem_q[i] <= rem_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_push_needs_ready : assert property (@(posedge clk_i) disable iff (rst_i)
        push |-> in_ready_o);
    a_count_bound : assert property (@(posedge clk_i)
        count_q <= CntFull);
    a_out_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(out_data_o)));
`endif

endmodule

// File: tb/tb_floo_hbm_resp_delay.sv
// Directed bench for floo_hbm_resp_delay: one instance at Latency=100/Depth=32,
// one at Latency=1/Depth=2, with hand-computed expectations per cycle.
module tb_floo_hbm_resp_delay;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic        a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_in_data, a_out_data;
    logic [5:0]  a_count;

    logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] b_in_data, b_out_data;
    logic [1:0]  b_count;

    floo_hbm_resp_delay #(
        .Latency   (100),
        .Depth     (32),
        .DataWidth (64)
    ) u_dut_a (
        .clk_i       (clk),
        .rst_i       (a_rst),
        .in_valid_i  (a_in_valid),
        .in_ready_o  (a_in_ready),
        .in_data_i   (a_in_data),
        .out_valid_o (a_out_valid),
        .out_ready_i (a_out_ready),
        .out_data_o  (a_out_data),
        .count_o     (a_count)
    );

    floo_hbm_resp_delay #(
        .Latency   (1),
        .Depth     (2),
        .DataWidth (64)
    ) u_dut_b (
        .clk_i       (clk),
        .rst_i       (b_rst),
        .in_valid_i  (b_in_valid),
        .in_ready_o  (b_in_ready),
        .in_data_i   (b_in_data),
        .out_valid_o (b_out_valid),
        .out_ready_i (b_out_ready),
        .out_data_o  (b_out_data),
        .count_o     (b_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid_cycle();
        @(negedge clk);
    endtask

    task automatic reset_a();
        a_rst       = 1'b1;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        a_in_data   = '0;
        next_cycle();
        next_cycle();
        mid_cycle();
        chk("rst_in_ready", 64'(a_in_ready), 64'd0);
        chk("rst_count", 64'(a_count), 64'd0);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        a_rst = 1'b0;
        next_cycle();
    endtask

    // n beats pushed back-to-back from cycle 10, sink always ready.
    task automatic latency_run(input int n, input logic [63:0] base, input string name);
        logic exp_v;
        reset_a();
        for (int c = 0; c <= 115 + n; c++) begin
            a_in_valid  = (c >= 10 && c < 10 + n);
            a_in_data   = (c >= 10) ? base + 64'(c - 10) : '0;
            a_out_ready = 1'b1;
            mid_cycle();
            exp_v = (c >= 110 && c < 110 + n);
            chk($sformatf("%s_valid_c%0d", name, c), 64'(a_out_valid), 64'(exp_v));
            if (exp_v)
                chk($sformatf("%s_data_c%0d", name, c), a_out_data, base + 64'(c - 110));
            if (c == 0)
                chk($sformatf("%s_ready_c0", name), 64'(a_in_ready), 64'd1);
            if (c == 10 + n)
                chk($sformatf("%s_count_full", name), 64'(a_count), 64'(n));
            if (c == 110 + n)
                chk($sformatf("%s_count_drained", name), 64'(a_count), 64'd0);
            next_cycle();
        end
    endtask

    // Offer a beat every cycle with the sink stalled, then either one pop at
    // cycle rel (single) or continuous draining from rel.
    task automatic fill_run(input bit single, input int rel, input string name);
        logic        exp_v;
        logic [63:0] exp_d;
        int          last;
        last = single ? rel + 3 : rel + 35;
        reset_a();
        for (int c = 0; c <= last; c++) begin
            a_in_valid  = (c < rel);
            a_in_data   = 64'(c);
            a_out_ready = single ? (c == rel) : (c >= rel);
            mid_cycle();
            if (c <= rel)
                chk($sformatf("%s_in_ready_c%0d", name, c), 64'(a_in_ready), 64'(c < 32));
            if (c == 32)
                chk($sformatf("%s_count_c32", name), 64'(a_count), 64'd32);
            exp_d = '0;
            if (c < 100) begin
                exp_v = 1'b0;
            end else if (single) begin
                exp_v = 1'b1;
                exp_d = (c <= rel) ? 64'd0 : 64'd1;
            end else if (c < rel) begin
                exp_v = 1'b1;
            end else if (c < rel + 32) begin
                exp_v = 1'b1;
                exp_d = 64'(c - rel);
            end else begin
                exp_v = 1'b0;
            end
            chk($sformatf("%s_valid_c%0d", name, c), 64'(a_out_valid), 64'(exp_v));
            if (exp_v)
                chk($sformatf("%s_data_c%0d", name, c), a_out_data, exp_d);
            if (single && c == rel + 1) begin
                chk($sformatf("%s_count_after_pop", name), 64'(a_count), 64'd31);
                chk($sformatf("%s_ready_after_pop", name), 64'(a_in_ready), 64'd1);
            end
            if (!single && c == rel + 32)
                chk($sformatf("%s_count_drained", name), 64'(a_count), 64'd0);
            next_cycle();
        end
    endtask

    task automatic reset_mid_run();
        reset_a();
        for (int c = 0; c <= 200; c++) begin
            a_rst       = (c == 50);
            a_in_valid  = (c >= 10 && c < 15) || (c == 60);
            a_in_data   = (c == 60) ? 64'h77 : 64'h50 + 64'(c);
            a_out_ready = 1'b1;
            mid_cycle();
            if (c == 50) begin
                chk("t5_count_pre_rst", 64'(a_count), 64'd5);
                chk("t5_ready_in_rst", 64'(a_in_ready), 64'd0);
            end
            if (c == 51) begin
                chk("t5_count_post_rst", 64'(a_count), 64'd0);
                chk("t5_ready_post_rst", 64'(a_in_ready), 64'd1);
            end
            chk($sformatf("t5_valid_c%0d", c), 64'(a_out_valid), 64'(c == 160));
            if (c == 160)
                chk("t5_data_c160", a_out_data, 64'h77);
            next_cycle();
        end
    endtask

    task automatic short_latency_run();
        logic exp_v;
        b_rst       = 1'b1;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        b_in_data   = '0;
        next_cycle();
        next_cycle();
        mid_cycle();
        chk("t6_rst_count", 64'(b_count), 64'd0);
        chk("t6_rst_valid", 64'(b_out_valid), 64'd0);
        b_rst = 1'b0;
        next_cycle();
        for (int c = 0; c <= 21; c++) begin
            b_in_valid  = (c <= 19);
            b_in_data   = 64'h100 + 64'(c);
            b_out_ready = 1'b1;
            mid_cycle();
            exp_v = (c >= 1 && c <= 20);
            if (c <= 19)
                chk($sformatf("t6_in_ready_c%0d", c), 64'(b_in_ready), 64'd1);
            chk($sformatf("t6_valid_c%0d", c), 64'(b_out_valid), 64'(exp_v));
            if (exp_v)
                chk($sformatf("t6_data_c%0d", c), b_out_data, 64'h100 + 64'(c - 1));
            chk($sformatf("t6_count_c%0d", c), 64'(b_count), exp_v ? 64'd1 : 64'd0);
            next_cycle();
        end
    endtask

    initial begin
        a_rst       = 1'b1;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        a_in_data   = '0;
        b_rst       = 1'b1;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        b_in_data   = '0;

        latency_run(1, 64'hA5, "t1");
        latency_run(4, 64'h1, "t2");
        fill_run(1'b1, 120, "t3");
        fill_run(1'b0, 150, "t4");
        reset_mid_run();
        short_latency_run();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
